// File: rtl/micro_waves_pkg.sv
// -----------------------------------------------------------------------------
// micro_waves_pkg
//   Shared definitions for the microwave controller front end.
//   - NUM_KEYS / KEY_CODE_W : keypad width and binary key-code width
//   - kbd_state_t           : keypad debounce FSM state encoding
//   - is_onehot()           : true when exactly one key line is set
//   - onehot_index()        : binary index of the set bit of a one-hot vector
// -----------------------------------------------------------------------------
package micro_waves_pkg;

  localparam int NUM_KEYS   = 10;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3,
    LOCKOUT      = 3'd4
  } kbd_state_t;

  // Clearing the lowest set bit leaves zero only for a single set bit.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    logic [NUM_KEYS-1:0] low_cleared;
    low_cleared = v & (v - NUM_KEYS'(1));
    return (v != '0) && (low_cleared == '0);
  endfunction

  // Only meaningful for a one-hot input; a zero vector maps to code 0.
  function automatic logic [KEY_CODE_W-1:0] onehot_index(input logic [NUM_KEYS-1:0] v);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        idx = KEY_CODE_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for level signals that are asynchronous to clk.
//   Each bit is synchronised independently; no multi-bit coherence is implied.
//   Reused for the keypad, door_closed and the start/stop/clear buttons.
//
//   Ports:
//     clk    in  1       destination clock, rising edge
//     resetn in  1       asynchronous active-low reset, clears both stages
//     d      in  DATA_W  asynchronous input levels
//     q      out DATA_W  synchronised levels, two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  // Stage p0 may go metastable; stage p1 gives it a full cycle to settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
//   Cleans the raw ten-key microwave keypad before the timer-entry control.
//   Synchronises the raw lines, waits for DEBOUNCE_CYCLES of stability before
//   accepting a press or a release, rejects multi-key chords, and never
//   auto-repeats: one key is reported per press/release cycle.  New entries are
//   blocked while enable is low (the magnetron is running).
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable sampled cycles needed for press/release (2..65535)
//
//   Ports:
//     clk        in  1           system clock, rising edge
//     resetn     in  1           asynchronous active-low reset
//     keys_raw   in  NUM_KEYS    raw key lines, active-high, bit k = digit k
//     enable     in  1           accept enable (driven by ~mag_on)
//     keyboard   out NUM_KEYS    debounced one-hot key level, zero when idle
//     key_valid  out 1           one-cycle strobe when a new key is accepted
//     key_code   out KEY_CODE_W  index of the last accepted key (held)
//
//   Latency: a key stable on keys_raw before edge 0 is reported after edge
//   DEBOUNCE_CYCLES+2; a release stable before edge R clears keyboard after
//   edge R+DEBOUNCE_CYCLES+2.
// -----------------------------------------------------------------------------
module keypad_debounce
  import micro_waves_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_KEYS-1:0]   keys_raw,
  input  logic                  enable,
  output logic [NUM_KEYS-1:0]   keyboard,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Stability counter increment that parks at CNT_MAX instead of wrapping,
  // so an arbitrarily long hold can never look like a fresh change.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [NUM_KEYS-1:0] sync_keys;
  logic [NUM_KEYS-1:0] sync_keys_prev;
  logic [NUM_KEYS-1:0] cand;
  logic [CNT_W-1:0]    cnt;

  kbd_state_t state;
  kbd_state_t state_nxt;

  logic cnt_clr;
  logic cand_load;
  logic key_load;
  logic key_clr;
  logic keys_zero;
  logic stable_done;

  // ---- input synchronisation ------------------------------------------------
  sync_2ff #(
    .DATA_W (NUM_KEYS)
  ) u_sync_keys (
    .clk    (clk),
    .resetn (resetn),
    .d      (keys_raw),
    .q      (sync_keys)
  );

  // ---- stability counter ----------------------------------------------------
  // cnt counts edges since sync_keys last changed (or since the FSM last
  // restarted a wait).  cnt >= DEBOUNCE_CYCLES-1 therefore means the current
  // sample has been stable for a full debounce window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_keys_prev <= '0;
      cnt            <= '0;
    end else begin
      sync_keys_prev <= sync_keys;
      if (cnt_clr || (sync_keys != sync_keys_prev)) begin
        cnt <= '0;
      end else begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  assign keys_zero   = (sync_keys == '0);
  assign stable_done = (cnt >= CNT_DONE);

  // ---- control FSM ----------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cand_load = 1'b0;
    key_load  = 1'b0;
    key_clr   = 1'b0;

    case (state)
      IDLE: begin
        // With enable low, keys are simply ignored here.
        if (!keys_zero && enable) begin
          state_nxt = PRESS_WAIT;
          cnt_clr   = 1'b1;
          cand_load = 1'b1;
        end
      end

      PRESS_WAIT: begin
        // Any deviation from the candidate (release, other key, extra key)
        // abandons the attempt; the count restarts from IDLE.
        if (sync_keys != cand) begin
          state_nxt = IDLE;
        end else if (!enable) begin
          state_nxt = LOCKOUT;
        end else if (stable_done) begin
          if (is_onehot(cand)) begin
            state_nxt = PRESSED;
            key_load  = 1'b1;
          end else begin
            // A stable chord is swallowed; wait for a full release.
            state_nxt = LOCKOUT;
          end
        end
      end

      PRESSED: begin
        // Keys added or swapped while held are ignored: no second report.
        if (!enable) begin
          state_nxt = LOCKOUT;
          key_clr   = 1'b1;
        end else if (keys_zero) begin
          state_nxt = RELEASE_WAIT;
          cnt_clr   = 1'b1;
        end
      end

      RELEASE_WAIT: begin
        if (!enable) begin
          state_nxt = LOCKOUT;
          key_clr   = 1'b1;
        end else if (!keys_zero) begin
          // Release bounce: resume the held key without a new strobe.
          state_nxt = PRESSED;
        end else if (stable_done) begin
          state_nxt = IDLE;
          key_clr   = 1'b1;
        end
      end

      LOCKOUT: begin
        key_clr = 1'b1;
        if (keys_zero && stable_done && enable) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        key_clr   = 1'b1;
      end
    endcase
  end

  // ---- candidate capture ----------------------------------------------------
  // Only compared while in PRESS_WAIT, which always loads it first.
  always_ff @(posedge clk) begin
    if (cand_load) begin
      cand <= sync_keys;
    end
  end

  // ---- registered outputs ---------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keyboard  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= key_load;
      if (key_load) begin
        keyboard <= cand;
        key_code <= onehot_index(cand);
      end else if (key_clr) begin
        keyboard <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
module tb_keypad_debounce;

  localparam int D = 4;

  localparam int M_IDLE = 0;
  localparam int M_PW   = 1;
  localparam int M_PR   = 2;
  localparam int M_RW   = 3;
  localparam int M_LK   = 4;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b1;
  logic [9:0] keys_raw = '0;
  logic       enable   = 1'b0;
  logic [9:0] keyboard;
  logic       key_valid;
  logic [3:0] key_code;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .keys_raw  (keys_raw),
    .enable    (enable),
    .keyboard  (keyboard),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stepc  = 0;
  int n_vld  = 0;
  int vld_step = 0;

  // Reference model: a timestamp view of the sampled key history.
  logic [9:0] m_s1, m_sync, m_prev, m_cand, m_kb;
  logic       m_vld;
  logic [3:0] m_code;
  int         m_mode;
  int         edge_n;
  int         t_clr;

  typedef struct {
    logic [9:0] keys;
    logic       en;
    logic [9:0] kb;
    logic       vld;
    logic [3:0] code;
  } vec_t;

  vec_t tbl [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_idx(input logic [9:0] v);
    for (int i = 0; i < 10; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_sync = '0; m_prev = '0; m_cand = '0; m_kb = '0;
    m_vld = 1'b0; m_code = '0; m_mode = M_IDLE; edge_n = 0; t_clr = 0;
  endtask

  // One rising edge: decisions use the samples visible before the edge;
  // "stable for D" means at least D edges since the last change or restart.
  task automatic model_edge();
    int  e;
    int  el;
    logic chg;
    logic restart;
    edge_n++;
    e       = edge_n;
    el      = e - t_clr;
    chg     = (m_sync != m_prev);
    restart = 1'b0;
    m_vld   = 1'b0;
    case (m_mode)
      M_IDLE: if (m_sync != '0 && enable) begin
        m_mode = M_PW; m_cand = m_sync; restart = 1'b1;
      end
      M_PW: begin
        if (m_sync != m_cand) m_mode = M_IDLE;
        else if (!enable) m_mode = M_LK;
        else if (el >= D) begin
          if ($countones(m_cand) == 1) begin
            m_mode = M_PR; m_kb = m_cand; m_code = key_idx(m_cand); m_vld = 1'b1;
          end else begin
            m_mode = M_LK;
          end
        end
      end
      M_PR: begin
        if (!enable) begin m_mode = M_LK; m_kb = '0; end
        else if (m_sync == '0) begin m_mode = M_RW; restart = 1'b1; end
      end
      M_RW: begin
        if (!enable) begin m_mode = M_LK; m_kb = '0; end
        else if (m_sync != '0) m_mode = M_PR;
        else if (el >= D) begin m_mode = M_IDLE; m_kb = '0; end
      end
      default: begin
        m_kb = '0;
        if (m_sync == '0 && enable && el >= D) m_mode = M_IDLE;
      end
    endcase
    if (chg || restart) t_clr = e;
    m_prev = m_sync;
    m_sync = m_s1;
    m_s1   = keys_raw;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [9:0] k, input logic en);
    keys_raw = k;
    enable   = en;
    @(posedge clk);
    if (resetn) model_edge();
    else        model_reset();
    #1;
    chk("model_keyboard",  32'(keyboard),  32'(m_kb));
    chk("model_key_valid", 32'(key_valid), 32'(m_vld));
    chk("model_key_code",  32'(key_code),  32'(m_code));
    stepc++;
    if (key_valid) begin
      n_vld++;
      vld_step = stepc;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(10'd0, 1'b1);
  endtask

  logic [9:0] k_r;
  logic       en_r;
  int         len_r;
  int         r;
  int         s0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state ----
    #1 resetn = 1'b0;
    model_reset();
    #1;
    chk("reset_keyboard",  32'(keyboard),  32'd0);
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_key_code",  32'(key_code),  32'd0);
    @(negedge clk);
    step(10'd0, 1'b1);
    step(10'd0, 1'b1);
    resetn = 1'b1;
    idle(4);

    // ---- clean press of key 3 (table) ----
    for (int i = 0; i < 32; i++) begin
      tbl[i].keys = (i < 20) ? 10'b0000001000 : 10'd0;
      tbl[i].en   = 1'b1;
      tbl[i].vld  = (i == 6);
      tbl[i].kb   = (i >= 6 && i < 26) ? 10'b0000001000 : 10'd0;
      tbl[i].code = (i >= 6) ? 4'd3 : 4'd0;
    end
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].keys, tbl[i].en);
      chk($sformatf("tbl%0d_keyboard", i),  32'(keyboard),  32'(tbl[i].kb));
      chk($sformatf("tbl%0d_key_valid", i), 32'(key_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_key_code", i),  32'(key_code),  32'(tbl[i].code));
    end
    idle(4);

    // ---- bounce on key 7 ----
    n_vld = 0;
    step(10'b0010000000, 1'b1);
    step(10'd0, 1'b1);
    step(10'b0010000000, 1'b1);
    step(10'd0, 1'b1);
    s0 = stepc;
    repeat (12) step(10'b0010000000, 1'b1);
    chk("bounce_strobe_count", 32'(n_vld), 32'd1);
    chk("bounce_latency", 32'(vld_step - (s0 + 1)), 32'd6);
    chk("bounce_key_code", 32'(key_code), 32'd7);
    idle(10);

    // ---- chord 2+5, then key 9 ----
    n_vld = 0;
    repeat (15) step(10'b0000100100, 1'b1);
    chk("chord_strobe_count", 32'(n_vld), 32'd0);
    chk("chord_keyboard", 32'(keyboard), 32'd0);
    idle(10);
    repeat (10) step(10'b1000000000, 1'b1);
    chk("after_chord_strobe_count", 32'(n_vld), 32'd1);
    chk("after_chord_key_code", 32'(key_code), 32'd9);
    chk("after_chord_keyboard", 32'(keyboard), 32'(10'b1000000000));
    idle(10);

    // ---- second key added while held ----
    n_vld = 0;
    repeat (10) step(10'b0000000010, 1'b1);
    repeat (5)  step(10'b0000010010, 1'b1);
    repeat (5)  step(10'b0000000010, 1'b1);
    chk("second_key_strobe_count", 32'(n_vld), 32'd1);
    chk("second_key_keyboard", 32'(keyboard), 32'(10'b0000000010));
    idle(10);

    // ---- enable drop while key 0 held ----
    n_vld = 0;
    repeat (10) step(10'b0000000001, 1'b1);
    chk("en_drop_accept", 32'(n_vld), 32'd1);
    step(10'b0000000001, 1'b0);
    chk("en_drop_keyboard", 32'(keyboard), 32'd0);
    repeat (3) step(10'b0000000001, 1'b0);
    n_vld = 0;
    repeat (10) step(10'b0000000001, 1'b1);
    chk("en_raise_held_strobe_count", 32'(n_vld), 32'd0);
    chk("en_raise_held_keyboard", 32'(keyboard), 32'd0);
    idle(10);
    repeat (10) step(10'b0000000001, 1'b1);
    chk("en_repress_strobe_count", 32'(n_vld), 32'd1);
    chk("en_repress_keyboard", 32'(keyboard), 32'(10'b0000000001));
    idle(10);

    // ---- reset mid-press on key 6 ----
    repeat (10) step(10'b0001000000, 1'b1);
    chk("pre_reset_keyboard", 32'(keyboard), 32'(10'b0001000000));
    resetn = 1'b0;
    #1;
    chk("mid_reset_keyboard",  32'(keyboard),  32'd0);
    chk("mid_reset_key_valid", 32'(key_valid), 32'd0);
    chk("mid_reset_key_code",  32'(key_code),  32'd0);
    model_reset();
    @(negedge clk);
    step(10'b0001000000, 1'b1);
    step(10'b0001000000, 1'b1);
    resetn = 1'b1;
    n_vld = 0;
    s0 = stepc;
    repeat (10) step(10'b0001000000, 1'b1);
    chk("post_reset_strobe_count", 32'(n_vld), 32'd1);
    chk("post_reset_latency", 32'(vld_step - (s0 + 1)), 32'd6);
    chk("post_reset_key_code", 32'(key_code), 32'd6);
    idle(10);

    // ---- randomized traffic against the model ----
    for (int seg = 0; seg < 260; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      k_r = 10'(1) << $urandom_range(0, 9);
      else if (r < 75) k_r = '0;
      else if (r < 88) k_r = 10'($urandom);
      else             k_r = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
      en_r  = ($urandom_range(0, 99) < 88);
      len_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
      repeat (len_r) step(k_r, en_r);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
